// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and counter sizing helper
package uart_pkg;

  localparam int OVERSAMPLE      = 16;
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;

  // Tick counter must hold both the 16-tick bit period and a longer stop period.
  function automatic int tick_width(input int sb_tick);
    return (sb_tick > OVERSAMPLE) ? $clog2(sb_tick) : $clog2(OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serial transmitter: start bit, DBIT data bits LSB-first, stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_done_tick,
  output logic            busy
);

  localparam int            SW      = tick_width(SB_TICK);
  localparam logic [SW-1:0] OS_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST  = 3'(DBIT - 1);

  tx_state_t       state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [2:0]      n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
  logic            done_next;

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    done_next  = 1'b0;
    tx_next    = 1'b1;
    case (state_reg)
      IDLE: begin
        if (tx_start) begin
          b_next     = din;
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == OS_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == OS_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_reg == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == SB_LAST) begin
            done_next  = 1'b1;
            s_next     = '0;
            state_next = IDLE;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level follows the state being entered so tx and busy move on the same edge.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
    end
  end

  // A reset landing on the final stop tick must not leak a completion pulse.
  assign tx_done_tick = done_next & ~reset;
  assign tx           = tx_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with 1 and 2 stop-bit instances
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       start0, start1;
  logic [7:0] din0, din1;
  logic       tx0, tx1, done0, done1, busy0, busy1;

  int total = 0;
  int bad   = 0;
  int tick_mode;
  int phase;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         act[2];
  int         kk[2];
  logic [7:0] cur[2];

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start0), .din(din0),
    .tx(tx0), .tx_done_tick(done0), .busy(busy0)
  );

  uart_tx #(.DBIT(8), .SB_TICK(32)) dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start1), .din(din1),
    .tx(tx1), .tx_done_tick(done1), .busy(busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // mode 0: tick every 4 cycles, mode 1: tick tied high
  initial begin
    s_tick = 1'b0;
    phase  = 0;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      s_tick = (tick_mode == 1) || (tick_mode == 0 && (phase % 4) == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  task automatic chk_range(input string name, input int v, input int lo, input int hi);
    total++;
    if (v < lo || v > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic mon_cycle(input int g, input int sb, input logic txv, input logic bsy,
                           input logic dn);
    int   idx;
    int   qsz;
    logic expb;
    bit   last;
    if (reset) begin
      act[g] = 1'b0;
      return;
    end
    if (!act[g] && txv == 1'b0) begin
      qsz = (g == 0) ? q0.size() : q1.size();
      chk("frame_expected", qsz != 0, 1);
      if (qsz != 0) begin
        cur[g] = (g == 0) ? q0.pop_front() : q1.pop_front();
        act[g] = 1'b1;
        kk[g]  = 0;
      end
    end
    if (act[g] && s_tick) begin
      idx  = kk[g] / 16;
      expb = (idx == 0) ? 1'b0 : (idx <= 8) ? cur[g][idx-1] : 1'b1;
      last = (kk[g] == 16 * 9 + sb - 1);
      chk("tx_bit", txv, expb);
      chk("busy_in_frame", bsy, 1);
      chk("done_tick", dn, last);
      kk[g]++;
      if (last) act[g] = 1'b0;
    end else begin
      chk("done_quiet", dn, 0);
    end
  endtask

  always @(negedge clk) mon_cycle(0, 16, tx0, busy0, done0);
  always @(negedge clk) mon_cycle(1, 32, tx1, busy1, done1);

  task automatic start_req(input int g, input logic [7:0] d);
    @(posedge clk);
    #1;
    if (g == 0) begin start0 = 1'b1; din0 = d; q0.push_back(d); end
    else        begin start1 = 1'b1; din1 = d; q1.push_back(d); end
    @(posedge clk);
    #1;
    if (g == 0) begin start0 = 1'b0; din0 = ~d; end
    else        begin start1 = 1'b0; din1 = ~d; end
  endtask

  task automatic wait_done(input int g, input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((g == 0) ? done0 : done1) begin
        cyc = i;
        break;
      end
    end
    chk("done_seen", cyc >= 0, 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset     = 1'b1;
    start0    = 1'b0;
    start1    = 1'b0;
    din0      = 8'h00;
    din1      = 8'h00;
    tick_mode = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_tx0", tx0, 1);
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_tx1", tx1, 1);
    chk("rst_busy1", busy1, 0);

    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("idle_tx", tx0, 1);
    chk("idle_busy", busy0, 0);

    // 0x41 at one tick per 4 cycles
    start_req(0, 8'h41);
    wait_done(0, 1000, cyc);
    chk_range("frame_cycles_41", cyc, 636, 639);
    @(negedge clk);
    chk("busy_after_done", busy0, 0);
    chk("tx_after_done", tx0, 1);

    // 0xA5 with ticks tied high, ignored mid-frame and coincident requests
    tick_mode = 1;
    repeat (3) @(posedge clk);
    @(posedge clk); #1 start0 = 1'b1; din0 = 8'hA5; q0.push_back(8'hA5);
    @(posedge clk); #1 start0 = 1'b0; din0 = 8'h00;
    repeat (49) @(posedge clk); #1 start0 = 1'b1; din0 = 8'hFF;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (109) @(posedge clk); #1 start0 = 1'b1; din0 = 8'hFF;
    @(negedge clk);
    chk("coincident_done", done0, 1);
    chk("coincident_busy", busy0, 1);
    @(posedge clk); #1 din0 = 8'h00; q0.push_back(8'h00);
    @(negedge clk);
    chk("gap_busy", busy0, 0);
    chk("gap_tx", tx0, 1);
    @(posedge clk); #1 start0 = 1'b0; din0 = 8'hFF;
    @(negedge clk);
    chk("b2b_start_tx", tx0, 0);
    chk("b2b_start_busy", busy0, 1);
    wait_done(0, 400, cyc);
    chk("b2b_frame_cycles", cyc, 158);

    // reset during data bit 3 of 0x55
    repeat (4) @(posedge clk);
    start_req(0, 8'h55);
    repeat (68) @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("pre_reset_bit3", tx0, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_reset_tx", tx0, 1);
    chk("post_reset_busy", busy0, 0);
    chk("post_reset_done", done0, 0);
    repeat (5) @(posedge clk);
    start_req(0, 8'h3C);
    wait_done(0, 400, cyc);
    chk("frame_cycles_3c", cyc, 159);

    // two stop bits on the SB_TICK=32 instance
    start_req(1, 8'h80);
    wait_done(1, 400, cyc);
    chk("frame_cycles_sb32", cyc, 175);
    @(negedge clk);
    chk("sb32_busy_after", busy1, 0);

    repeat (20) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("mon0_idle", act[0], 0);
    chk("mon1_idle", act[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
